// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master: a command starts a 1..16 beat read or write burst.
// A three-state FSM (IDLE/BURST/DONE) registers every bus output and ends with a done/status pulse.
module wb_burst_master #(
  parameter int TIMEOUT = 256
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic [1:0]  status,
  output logic [4:0]  beats_done,
  output logic [31:0] m_wb_adr_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_we_o,
  output logic [31:0] m_wb_dat_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic [2:0]  m_wb_cti_o,
  output logic [1:0]  m_wb_bte_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [3:0]  len_q, len_d;
  logic [4:0]  issued_q, issued_d;
  logic [4:0]  beats_q, beats_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic [2:0]  cti_q, cti_d;

  logic ack_v, err_v, load, abort;

  // Handshakes: a command is taken on a cycle with cmd_valid && cmd_ready; a write word is
  // taken on a cycle with wdata_valid && wdata_ready; rdata_valid is a strobe with no stall.
  assign cmd_ready = (state_q == S_IDLE) && !wb_rst;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    issued_d      = issued_q;
    beats_d       = beats_q;
    tcnt_d        = tcnt_q;
    status_d      = status_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    adr_d         = adr_q;
    sel_d         = sel_q;
    we_d          = we_q;
    dat_d         = dat_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    cti_d         = cti_q;
    wdata_ready   = 1'b0;
    load          = 1'b0;
    abort         = 1'b0;
    // Responses only count while a strobe is outstanding.
    ack_v         = stb_q && m_wb_ack_i;
    err_v         = stb_q && m_wb_err_i;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d  = S_BURST;
          base_d   = cmd_addr & 32'hFFFF_FFFC;
          len_d    = cmd_len;
          we_d     = cmd_we;
          sel_d    = cmd_sel;
          issued_d = 5'd0;
          beats_d  = 5'd0;
          tcnt_d   = 16'd0;
          status_d = 2'b00;
          cyc_d    = 1'b1;
        end
      end
      S_BURST: begin
        if (err_v) begin
          abort    = 1'b1;
          status_d = 2'b01;
        end else if (stb_q && !ack_v && tcnt_q == TO_LAST) begin
          abort    = 1'b1;
          status_d = 2'b10;
        end else begin
          if (ack_v) begin
            beats_d = beats_q + 5'd1;
            if (!we_q) begin
              rdata_d       = m_wb_dat_i;
              rdata_valid_d = 1'b1;
            end
          end
          if (ack_v && beats_q == {1'b0, len_q}) begin
            state_d = S_DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = 4'd0;
            cti_d   = 3'b000;
          end else begin
            load = (issued_q <= {1'b0, len_q}) && (!stb_q || ack_v) && (!we_q || wdata_valid);
            if (load) begin
              stb_d       = 1'b1;
              adr_d       = base_q + {25'd0, issued_q, 2'b00};
              issued_d    = issued_q + 5'd1;
              tcnt_d      = 16'd0;
              wdata_ready = we_q;
              if (we_q) dat_d = wdata;
              if (len_q == 4'd0)                    cti_d = 3'b000;
              else if (issued_q == {1'b0, len_q})   cti_d = 3'b111;
              else                                  cti_d = 3'b010;
            end else if (ack_v) begin
              stb_d  = 1'b0;
              tcnt_d = 16'd0;
            end else if (stb_q) begin
              tcnt_d = tcnt_q + 16'd1;
            end
          end
        end
        if (abort) begin
          state_d = S_DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'd0;
          cti_d   = 3'b000;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q       <= S_IDLE;
      base_q        <= 32'd0;
      len_q         <= 4'd0;
      issued_q      <= 5'd0;
      beats_q       <= 5'd0;
      tcnt_q        <= 16'd0;
      status_q      <= 2'b00;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      adr_q         <= 32'd0;
      sel_q         <= 4'd0;
      we_q          <= 1'b0;
      dat_q         <= 32'd0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      cti_q         <= 3'b000;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      beats_q       <= beats_d;
      tcnt_q        <= tcnt_d;
      status_q      <= status_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      adr_q         <= adr_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      dat_q         <= dat_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      cti_q         <= cti_d;
    end
  end

  assign done        = (state_q == S_DONE);
  assign status      = status_q;
  assign beats_done  = beats_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign m_wb_adr_o  = adr_q;
  assign m_wb_sel_o  = sel_q;
  assign m_wb_we_o   = we_q;
  assign m_wb_dat_o  = dat_q;
  assign m_wb_cyc_o  = cyc_q;
  assign m_wb_stb_o  = stb_q;
  assign m_wb_cti_o  = cti_q;
  assign m_wb_bte_o  = 2'b00;
  assign dbg_state   = state_q;

endmodule
